age_rs: RTL and testbench
=========================

Name: age_rs

Overview:
- Parametrised, oldest-first reservation station. Sits between dispatch and the FU issue stage.
- Accepts up to DISPATCH_W renamed instructions per cycle and wakes source operands from CDB_W completion tags.
- Issues up to ISSUE_W ready instructions per cycle, selected by an age matrix (not PC), onto specific free FU instances.
- Adds same-cycle wakeup of dispatching instructions and a full squash.

Parameters:
- N_ENTRY, 16, number of RS entries.
- DISPATCH_W, 3, dispatch slots per cycle; slot 0 is oldest in program order.
- ISSUE_W, 3, issue slots per cycle; slot 0 holds the oldest issued instruction.
- CDB_W, 3, tag broadcasts per cycle.
- PR_W, 6, physical register tag width.
- N_ALU, 3, ALU instances.
- N_MULT, 2, multiplier instances.
- N_LS, 2, load/store instances.
- N_BR, 1, branch instances.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- squash  in  1  flush all entries
- disp_pckt  in  DISPATCH_W x RS_IN_PACKET  dispatch packets; .valid qualifies each
- disp_stall  out  DISPATCH_W  bit k high when slot k cannot be accepted this cycle
- cdb_valid  in  CDB_W  broadcast valid
- cdb_tag  in  CDB_W x PR_W  completing physical register
- alu_free  in  N_ALU  per-instance ready
- mult_free  in  N_MULT  per-instance ready
- ls_free  in  N_LS  per-instance ready
- br_free  in  N_BR  per-instance ready
- issue_pckt  out  ISSUE_W x RS_S_PACKET  issued instructions; .valid qualifies each
- issue_fu_idx  out  ISSUE_W x 2  instance index within class
- free_count  out  $clog2(N_ENTRY+1)  free entries (registered state)

Behaviour:
- State per entry: RS_IN_PACKET plus a valid bit, and an N_ENTRY x N_ENTRY age matrix. age[i][j]=1 means entry i is older than entry j.
- Reset or squash (next edge):
  - All entries invalid, age matrix 0, free_count = N_ENTRY.
  - All issue_pckt.valid = 0 combinationally while no entry is valid.
  - When squash is high, dispatches in that cycle are dropped and issue outputs are forced invalid that cycle.
- Stall:
  - disp_stall[k] = (free_count <= k), combinational from registered state.
  - Entries freed by issue this cycle are not reusable until the next cycle.
  - Dispatch must present slots in order. A valid packet on a stalled slot is ignored.
- Allocation:
  - Accepted slot k takes the k-th lowest-index free entry.
  - The new entry is younger than every existing valid entry and every lower-numbered same-cycle slot: clear its row, set its column for those entries.
- Wakeup:
  - For any valid entry, a source becomes ready if its tag matches any cdb_tag with cdb_valid.
  - The same compare is applied to dispatching packets before they are written, so a tag broadcast in the dispatch cycle is not lost.
  - Tag 0 never matches (hardwired zero register is always ready).
- Ready:
  - Entry eligible = valid & src1 ready & src2 ready, using post-wakeup values this cycle.
  - Dispatched entries can issue no earlier than the next cycle.
- Select: ISSUE_W chained stages. Stage s:
  - Picks the oldest eligible, not-yet-selected entry whose FU class still has a free instance after earlier stages: an entry with no older candidate in that set.
  - Assigns the lowest-index free instance of that class and removes it from the free vector passed to stage s+1.
  - Emits valid=0 if nothing qualifies.
- Issued entries become invalid at the next edge. Their age rows and columns are don't-care until reallocated.
- Simultaneous events: issue, wakeup and allocation may all occur in one cycle; they never target the same entry.
- free_count: free_count_next = free_count − accepted + issued, clamped between 0 and N_ENTRY by construction. Its correctness must be asserted.

Decomposition:
- Package (shared):
  - RS_IN_PACKET, RS_S_PACKET, FU_SELECT class encodings, and PR_W.
  - Issue slot fields map 1:1 from RS_IN_PACKET, with fu_sel rewritten to the issued instance.
- Sub-module rs_age_select:
  - One select stage, taking the eligible vector, age matrix, and per-class free vectors.
  - Outputs a one-hot grant, instance index, and updated free vectors.
  - age_rs instantiates ISSUE_W of them in a chain via generate.

Test Plan:
- Reset, then dispatch 3 ready ALU ops into an empty RS with all FUs free → next cycle all 3 issue, slot 0 = oldest, issue_fu_idx 0,1,2; free_count returns 16.
- Fill all 16 entries with unready ops → free_count=0, disp_stall=3'b111; issue one entry via CDB wakeup → next cycle disp_stall=3'b110.
- Dispatch an op waiting on tag 5 in the same cycle cdb_tag=5 is broadcast → entry stored ready, issues the following cycle.
- Five ready MULT ops of differing age with mult_free=2'b11 → the two oldest issue in age order, regardless of PC or entry index.
- Two ready ALU and one ready BR with br_free=0 and alu_free=3'b010 → only the oldest ALU issues on instance 1; the BR waits.
- Squash asserted with 10 valid entries and a concurrent dispatch → issue invalid that cycle, next cycle free_count=16, no stale issue.

Source files
------------

// File: rtl/age_rs_pkg.sv
// Shared types for the age-ordered reservation station: FU classes, dispatch/issue packets.
// Issue packets mirror dispatch packets, with fu_sel carrying the granted instance.
package age_rs_pkg;

  localparam int PR_W = 6;
  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MULT = 2'd1,
    FU_LS   = 2'd2,
    FU_BR   = 2'd3
  } fu_class_e;

  typedef struct packed {
    fu_class_e  fu_class;
    logic [1:0] inst;
  } fu_select_t;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    fu_select_t      fu_sel;
    logic [PR_W-1:0] dest_tag;
    logic [PR_W-1:0] src1_tag;
    logic            src1_rdy;
    logic [PR_W-1:0] src2_tag;
    logic            src2_rdy;
  } rs_in_packet_t;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    fu_select_t      fu_sel;
    logic [PR_W-1:0] dest_tag;
    logic [PR_W-1:0] src1_tag;
    logic [PR_W-1:0] src2_tag;
  } rs_s_packet_t;

  function automatic rs_s_packet_t to_issue(rs_in_packet_t p, logic [1:0] inst);
    rs_s_packet_t o;
    o.valid           = 1'b1;
    o.pc              = p.pc;
    o.fu_sel.fu_class = p.fu_sel.fu_class;
    o.fu_sel.inst     = inst;
    o.dest_tag        = p.dest_tag;
    o.src1_tag        = p.src1_tag;
    o.src2_tag        = p.src2_tag;
    return o;
  endfunction

  function automatic logic [1:0] low_idx(logic [3:0] v);
    logic [1:0] r;
    r = '0;
    for (int n = 3; n >= 0; n--) begin
      if (v[n]) r = 2'(n);
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// One select stage: grants the oldest eligible entry whose FU class still has a free instance.
// Purely combinational; consumes the lowest-index free instance of the granted class.
module rs_age_select
  import age_rs_pkg::*;
#(
  parameter int N_ENTRY = 16,
  parameter int N_ALU   = 3,
  parameter int N_MULT  = 2,
  parameter int N_LS    = 2,
  parameter int N_BR    = 1
) (
  input  logic      [N_ENTRY-1:0]              elig,
  input  logic      [N_ENTRY-1:0][N_ENTRY-1:0] age,
  input  fu_class_e [N_ENTRY-1:0]              cls,
  input  logic      [N_ALU-1:0]                alu_free,
  input  logic      [N_MULT-1:0]               mult_free,
  input  logic      [N_LS-1:0]                 ls_free,
  input  logic      [N_BR-1:0]                 br_free,
  output logic      [N_ENTRY-1:0]              grant,
  output logic      [1:0]                      fu_idx,
  output logic      [N_ALU-1:0]                alu_left,
  output logic      [N_MULT-1:0]               mult_left,
  output logic      [N_LS-1:0]                 ls_left,
  output logic      [N_BR-1:0]                 br_left
);

  logic [3:0] fv [4];
  logic [3:0] lv [4];
  logic [N_ENTRY-1:0] cand;
  logic [1:0] gcls;

  always_comb begin
    fv[0] = 4'(alu_free);
    fv[1] = 4'(mult_free);
    fv[2] = 4'(ls_free);
    fv[3] = 4'(br_free);
    cand  = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      cand[i] = elig[i] & (|fv[cls[i]]);
    end
  end

  // Winner is a candidate with no older candidate (age[j][i]: j older than i).
  always_comb begin
    logic older;
    grant = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      older = 1'b0;
      for (int j = 0; j < N_ENTRY; j++) begin
        if (cand[j] && age[j][i]) older = 1'b1;
      end
      grant[i] = cand[i] & ~older;
    end
  end

  always_comb begin
    gcls   = 2'd0;
    fu_idx = '0;
    lv     = fv;
    for (int i = 0; i < N_ENTRY; i++) begin
      if (grant[i]) gcls = cls[i];
    end
    if (|grant) begin
      fu_idx           = low_idx(fv[gcls]);
      lv[gcls][fu_idx] = 1'b0;
    end
    alu_left  = N_ALU'(lv[0]);
    mult_left = N_MULT'(lv[1]);
    ls_left   = N_LS'(lv[2]);
    br_left   = N_BR'(lv[3]);
  end

endmodule

// File: rtl/age_rs.sv
// Oldest-first reservation station with CDB wakeup, age-matrix select and full squash.
// Dispatch-to-issue is one cycle minimum; disp_stall[k] is set when fewer than k+1 entries are free.
module age_rs
  import age_rs_pkg::*;
#(
  parameter int N_ENTRY    = 16,
  parameter int DISPATCH_W = 3,
  parameter int ISSUE_W    = 3,
  parameter int CDB_W      = 3,
  parameter int N_ALU      = 3,
  parameter int N_MULT     = 2,
  parameter int N_LS       = 2,
  parameter int N_BR       = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  squash,
  input  rs_in_packet_t [DISPATCH_W-1:0]        disp_pckt,
  output logic          [DISPATCH_W-1:0]        disp_stall,
  input  logic          [CDB_W-1:0]             cdb_valid,
  input  logic          [CDB_W-1:0][PR_W-1:0]   cdb_tag,
  input  logic          [N_ALU-1:0]             alu_free,
  input  logic          [N_MULT-1:0]            mult_free,
  input  logic          [N_LS-1:0]              ls_free,
  input  logic          [N_BR-1:0]              br_free,
  output rs_s_packet_t  [ISSUE_W-1:0]           issue_pckt,
  output logic          [ISSUE_W-1:0][1:0]      issue_fu_idx,
  output logic          [$clog2(N_ENTRY+1)-1:0] free_count
);

  localparam int CNT_W = $clog2(N_ENTRY+1);
  localparam int IDX_W = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;

  rs_in_packet_t ent   [N_ENTRY];
  rs_in_packet_t woke  [N_ENTRY];
  rs_in_packet_t ent_n [N_ENTRY];
  logic      [N_ENTRY-1:0]              valid, valid_n, elig, issued;
  logic      [N_ENTRY-1:0][N_ENTRY-1:0] age, age_n;
  fu_class_e [N_ENTRY-1:0]              cls;
  logic      [CNT_W-1:0]                n_acc, n_iss, free_pop;

  function automatic logic hit(logic [PR_W-1:0] t, logic [CDB_W-1:0] v,
                               logic [CDB_W-1:0][PR_W-1:0] tags);
    logic h;
    h = 1'b0;
    for (int c = 0; c < CDB_W; c++) begin
      if (v[c] && tags[c] == t && t != '0) h = 1'b1;
    end
    return h;
  endfunction

  function automatic rs_in_packet_t wake(rs_in_packet_t p, logic [CDB_W-1:0] v,
                                         logic [CDB_W-1:0][PR_W-1:0] tags);
    rs_in_packet_t o;
    o          = p;
    o.src1_rdy = p.src1_rdy | (p.src1_tag == '0) | hit(p.src1_tag, v, tags);
    o.src2_rdy = p.src2_rdy | (p.src2_tag == '0) | hit(p.src2_tag, v, tags);
    return o;
  endfunction

  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) begin
      woke[i] = wake(ent[i], cdb_valid, cdb_tag);
      elig[i] = valid[i] & woke[i].src1_rdy & woke[i].src2_rdy;
      cls[i]  = ent[i].fu_sel.fu_class;
    end
  end

  always_comb begin
    for (int k = 0; k < DISPATCH_W; k++) begin
      disp_stall[k] = (free_count <= CNT_W'(k));
    end
  end

  logic [ISSUE_W:0][N_ENTRY-1:0] taken;
  logic [ISSUE_W-1:0][N_ENTRY-1:0] grant;
  logic [ISSUE_W-1:0][1:0] sel_idx;
  logic [ISSUE_W:0][N_ALU-1:0]  alu_ch;
  logic [ISSUE_W:0][N_MULT-1:0] mult_ch;
  logic [ISSUE_W:0][N_LS-1:0]   ls_ch;
  logic [ISSUE_W:0][N_BR-1:0]   br_ch;

  assign taken[0]   = '0;
  assign alu_ch[0]  = alu_free;
  assign mult_ch[0] = mult_free;
  assign ls_ch[0]   = ls_free;
  assign br_ch[0]   = br_free;

  for (genvar s = 0; s < ISSUE_W; s++) begin : g_sel
    rs_age_select #(
      .N_ENTRY(N_ENTRY), .N_ALU(N_ALU), .N_MULT(N_MULT), .N_LS(N_LS), .N_BR(N_BR)
    ) u_sel (
      .elig      (elig & ~taken[s]),
      .age       (age),
      .cls       (cls),
      .alu_free  (alu_ch[s]),
      .mult_free (mult_ch[s]),
      .ls_free   (ls_ch[s]),
      .br_free   (br_ch[s]),
      .grant     (grant[s]),
      .fu_idx    (sel_idx[s]),
      .alu_left  (alu_ch[s+1]),
      .mult_left (mult_ch[s+1]),
      .ls_left   (ls_ch[s+1]),
      .br_left   (br_ch[s+1])
    );
    assign taken[s+1] = taken[s] | grant[s];
  end

  always_comb begin
    for (int s = 0; s < ISSUE_W; s++) begin
      issue_pckt[s]   = '0;
      issue_fu_idx[s] = '0;
      if (!squash) begin
        for (int i = 0; i < N_ENTRY; i++) begin
          if (grant[s][i]) begin
            issue_pckt[s]   = to_issue(ent[i], sel_idx[s]);
            issue_fu_idx[s] = sel_idx[s];
          end
        end
      end
    end
    issued = squash ? '0 : taken[ISSUE_W];
    n_iss  = CNT_W'($countones(issued));
  end

  // Slot k takes the next lowest free entry; it is younger than all occupants and earlier slots.
  always_comb begin
    logic [N_ENTRY-1:0] avail, occ;
    logic [IDX_W-1:0]   slot;
    logic               found;
    avail   = ~valid;
    occ     = valid;
    valid_n = valid & ~issued;
    age_n   = age;
    n_acc   = '0;
    slot    = '0;
    found   = 1'b0;
    for (int i = 0; i < N_ENTRY; i++) ent_n[i] = woke[i];
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (disp_pckt[k].valid && !disp_stall[k] && !squash) begin
        found = 1'b0;
        for (int i = 0; i < N_ENTRY; i++) begin
          if (avail[i] && !found) begin
            found = 1'b1;
            slot  = IDX_W'(i);
          end
        end
        if (found) begin
          avail[slot]   = 1'b0;
          valid_n[slot] = 1'b1;
          ent_n[slot]   = wake(disp_pckt[k], cdb_valid, cdb_tag);
          age_n[slot]   = '0;
          for (int j = 0; j < N_ENTRY; j++) age_n[j][slot] = occ[j];
          occ[slot]     = 1'b1;
          n_acc         = n_acc + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      valid      <= '0;
      age        <= '0;
      free_count <= CNT_W'(N_ENTRY);
    end else begin
      valid      <= valid_n;
      age        <= age_n;
      free_count <= free_count - n_acc + n_iss;
    end
    for (int i = 0; i < N_ENTRY; i++) ent[i] <= ent_n[i];
  end

  assign free_pop = CNT_W'($countones(~valid));

  a_free_count_match: assert property (@(posedge clock) disable iff (reset)
    free_count == free_pop && free_count <= CNT_W'(N_ENTRY));

  a_free_chain_sane: assert property (@(posedge clock) disable iff (reset)
    (alu_ch[ISSUE_W] & ~alu_free) == '0 && (mult_ch[ISSUE_W] & ~mult_free) == '0 &&
    (ls_ch[ISSUE_W] & ~ls_free) == '0 && (br_ch[ISSUE_W] & ~br_free) == '0);

endmodule

// File: tb/tb_age_rs.sv
// Directed bench for age_rs: expected issues are queued by stimulus and popped by a negedge monitor.
`timescale 1ns/1ps
module tb_age_rs;
  import age_rs_pkg::*;

  logic clock = 1'b0;
  logic reset, squash;
  rs_in_packet_t [2:0]         disp_pckt;
  logic          [2:0]         disp_stall;
  logic          [2:0]         cdb_valid;
  logic          [2:0][PR_W-1:0] cdb_tag;
  logic          [2:0]         alu_free;
  logic          [1:0]         mult_free;
  logic          [1:0]         ls_free;
  logic          [0:0]         br_free;
  rs_s_packet_t  [2:0]         issue_pckt;
  logic          [2:0][1:0]    issue_fu_idx;
  logic          [4:0]         free_count;

  age_rs dut (
    .clock(clock), .reset(reset), .squash(squash),
    .disp_pckt(disp_pckt), .disp_stall(disp_stall),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .alu_free(alu_free), .mult_free(mult_free), .ls_free(ls_free), .br_free(br_free),
    .issue_pckt(issue_pckt), .issue_fu_idx(issue_fu_idx), .free_count(free_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [21:0] exp_q [$];
  logic [21:0] got, want;

  always @(negedge clock) begin
    if (!reset) begin
      for (int s = 0; s < 3; s++) begin
        if (issue_pckt[s].valid) begin
          checks++;
          got = {issue_pckt[s].pc, issue_pckt[s].fu_sel.fu_class,
                 issue_pckt[s].fu_sel.inst, issue_fu_idx[s]};
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected slot %0d got %h expected none", s, got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL issue_slot%0d got %h expected %h", s, got, want);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic expect_issue(input logic [15:0] pc, input fu_class_e c, input logic [1:0] inst);
    exp_q.push_back({pc, c, inst, inst});
  endtask

  task automatic clr();
    disp_pckt = '0;
    cdb_valid = '0;
    cdb_tag   = '0;
  endtask

  task automatic put(input int k, input logic [15:0] pc, input fu_class_e c,
                     input logic [PR_W-1:0] t1, input logic r1);
    disp_pckt[k].valid           = 1'b1;
    disp_pckt[k].pc              = pc;
    disp_pckt[k].fu_sel.fu_class = c;
    disp_pckt[k].fu_sel.inst     = 2'd0;
    disp_pckt[k].dest_tag        = PR_W'(40 + k);
    disp_pckt[k].src1_tag        = t1;
    disp_pckt[k].src1_rdy        = r1;
    disp_pckt[k].src2_tag        = '0;
    disp_pckt[k].src2_rdy        = 1'b1;
  endtask

  task automatic bcast(input int c, input logic [PR_W-1:0] t);
    cdb_valid[c] = 1'b1;
    cdb_tag[c]   = t;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int rest [$];
    reset = 1'b1; squash = 1'b0; clr();
    alu_free = 3'b111; mult_free = 2'b11; ls_free = 2'b11; br_free = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("reset_free_count", free_count, 16);
    chk("reset_stall", disp_stall, 0);
    chk("reset_issue_valid", {issue_pckt[2].valid, issue_pckt[1].valid, issue_pckt[0].valid}, 0);

    // three ready ALU ops issue together next cycle, oldest in slot 0
    put(0, 16'h100, FU_ALU, 0, 1); put(1, 16'h104, FU_ALU, 0, 1); put(2, 16'h108, FU_ALU, 0, 1);
    expect_issue(16'h100, FU_ALU, 0); expect_issue(16'h104, FU_ALU, 1); expect_issue(16'h108, FU_ALU, 2);
    step(); clr();
    chk("t1_fc_after_dispatch", free_count, 13);
    step();
    chk("t1_fc_after_issue", free_count, 16);

    // fill all entries with ops waiting on tags 10..25
    for (int n = 0; n < 16; n++) begin
      put(n % 3, 16'h200 + 16'(4 * n), FU_ALU, PR_W'(10 + n), 0);
      if (n % 3 == 2 || n == 15) begin step(); clr(); end
    end
    chk("t2_fc_full", free_count, 0);
    chk("t2_stall_full", disp_stall, 3'b111);
    bcast(0, 6'd20);
    expect_issue(16'h228, FU_ALU, 0);
    step(); clr();
    chk("t2_stall_one_free", disp_stall, 3'b110);
    chk("t2_fc_one_free", free_count, 1);
    for (int n = 0; n < 16; n++) if (n != 10) rest.push_back(n);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 3; c++) begin
        bcast(c, PR_W'(10 + rest[3*g + c]));
        expect_issue(16'h200 + 16'(4 * rest[3*g + c]), FU_ALU, 2'(c));
      end
      step(); clr();
    end
    chk("t2_fc_drained", free_count, 16);

    // dispatch-cycle wakeup must not be lost
    put(0, 16'h300, FU_ALU, 6'd5, 0);
    bcast(0, 6'd5);
    expect_issue(16'h300, FU_ALU, 0);
    step(); clr();
    chk("t3_fc_after_dispatch", free_count, 15);
    step();
    chk("t3_fc_after_issue", free_count, 16);

    // MULT ops where entry index and PC disagree with age
    mult_free = 2'b00;
    put(0, 16'h600, FU_ALU, 6'd30, 0); put(1, 16'h4F0, FU_MULT, 0, 1); put(2, 16'h604, FU_ALU, 6'd31, 0);
    step(); clr();
    put(0, 16'h4E0, FU_MULT, 0, 1); put(1, 16'h4D0, FU_MULT, 0, 1);
    step(); clr();
    bcast(0, 6'd30); bcast(1, 6'd31);
    expect_issue(16'h600, FU_ALU, 0); expect_issue(16'h604, FU_ALU, 1);
    step(); clr();
    put(0, 16'h400, FU_MULT, 0, 1); put(1, 16'h410, FU_MULT, 0, 1);
    step(); clr();
    chk("t4_fc_five_mult", free_count, 11);
    mult_free = 2'b11;
    expect_issue(16'h4F0, FU_MULT, 0); expect_issue(16'h4E0, FU_MULT, 1);
    expect_issue(16'h4D0, FU_MULT, 0); expect_issue(16'h400, FU_MULT, 1);
    expect_issue(16'h410, FU_MULT, 0);
    step(); step(); step();
    chk("t4_fc_drained", free_count, 16);

    // limited ALU instance, branch unit busy
    alu_free = 3'b000; br_free = 1'b0;
    put(0, 16'h500, FU_ALU, 0, 1); put(1, 16'h504, FU_BR, 0, 1); put(2, 16'h508, FU_ALU, 0, 1);
    step(); clr();
    alu_free = 3'b010;
    expect_issue(16'h500, FU_ALU, 1);
    step();
    alu_free = 3'b000;
    chk("t5_fc_one_issued", free_count, 14);
    step();
    alu_free = 3'b111; br_free = 1'b1;
    expect_issue(16'h504, FU_BR, 0); expect_issue(16'h508, FU_ALU, 0);
    step();
    chk("t5_fc_drained", free_count, 16);

    // squash with 10 valid entries and a concurrent dispatch
    alu_free = 3'b000;
    for (int n = 0; n < 10; n++) begin
      put(n % 3, 16'h700 + 16'(4 * n), FU_ALU, 0, 1);
      if (n % 3 == 2 || n == 9) begin step(); clr(); end
    end
    chk("t6_fc_ten_valid", free_count, 6);
    squash = 1'b1; alu_free = 3'b111;
    put(0, 16'h800, FU_ALU, 0, 1); put(1, 16'h804, FU_ALU, 0, 1); put(2, 16'h808, FU_ALU, 0, 1);
    #1;
    chk("t6_squash_issue_valid", {issue_pckt[2].valid, issue_pckt[1].valid, issue_pckt[0].valid}, 0);
    step();
    squash = 1'b0; clr();
    chk("t6_fc_after_squash", free_count, 16);
    chk("t6_stall_after_squash", disp_stall, 0);
    step(); step(); step();

    chk("expected_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
